// File: rtl/memory_access_if.sv
// memory_access_if: bundles the execute-side operands, the preload port and the
// memory-stage results of the Y86-64 SEQ memory stage.
//   icode/instr_valid/imem_error  : instruction code and fetch status
//   valA/valE/valP                : operand A, ALU result, incremented PC
//   load_en/load_addr/load_data   : quadword preload port
//   valM/dmem_error/stat/halted   : read data, range fault, status, sticky stop
// master drives the operands and preload port; slave is the memory stage.
interface memory_access_if;
  logic [3:0]  icode;
  logic        instr_valid;
  logic        imem_error;
  logic [63:0] valA;
  logic [63:0] valE;
  logic [63:0] valP;
  logic        load_en;
  logic [63:0] load_addr;
  logic [63:0] load_data;
  logic [63:0] valM;
  logic        dmem_error;
  logic [2:0]  stat;
  logic        halted;

  modport master (
    output icode, instr_valid, imem_error, valA, valE, valP,
    output load_en, load_addr, load_data,
    input  valM, dmem_error, stat, halted
  );

  modport slave (
    input  icode, instr_valid, imem_error, valA, valE, valP,
    input  load_en, load_addr, load_data,
    output valM, dmem_error, stat, halted
  );
endinterface

// File: rtl/memory_access.sv
// memory_access: SEQ memory stage. Decodes the data-memory access from icode,
// performs one little-endian 8-byte read or write, computes the processor
// status and latches a sticky stopped state on any non-AOK status.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset (memory contents are kept)
//   bus    : memory_access_if.slave (operands, preload port, valM/stat/etc.)
module memory_access #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input logic            clk,
  input logic            reset,
  memory_access_if.slave bus
);

  localparam int unsigned AW       = (MEM_BYTES > 2) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] LastAddr = 64'(MEM_BYTES - 8);

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;

  typedef enum logic [0:0] {StRun, StStopped} state_e;

  state_e      r_state;
  logic [2:0]  r_stat_q;
  logic [7:0]  r_mem [MEM_BYTES];

  logic          w_wr;
  logic          w_rd;
  logic [63:0]   w_addr;
  logic [63:0]   w_wdata;
  logic          w_addr_ok;
  logic          w_dmem_error;
  logic [2:0]    w_stat_run;
  logic          w_halted;
  logic [AW-1:0] w_rd_idx;
  logic [AW-1:0] w_st_idx;
  logic [AW-1:0] w_ld_idx;
  logic [63:0]   w_rdata;
  logic          w_stage_we;
  logic          w_load_we;

  // Access decode
  always_comb begin
    w_wr    = 1'b0;
    w_rd    = 1'b0;
    w_addr  = bus.valE;
    w_wdata = bus.valA;
    case (bus.icode)
      4'h4, 4'hA: w_wr = 1'b1;
      4'h8: begin
        w_wr    = 1'b1;
        w_wdata = bus.valP;
      end
      4'h5: w_rd = 1'b1;
      4'h9, 4'hB: begin
        w_rd   = 1'b1;
        w_addr = bus.valA;
      end
      default: ;
    endcase
  end

  // Full 64-bit compare: no truncation, no wrap-around.
  assign w_addr_ok    = (w_addr <= LastAddr);
  assign w_dmem_error = (w_rd || w_wr) && !w_addr_ok;

  always_comb begin
    if (bus.imem_error)        w_stat_run = StatAdr;
    else if (!bus.instr_valid) w_stat_run = StatIns;
    else if (bus.icode == 4'h0) w_stat_run = StatHlt;
    else if (w_dmem_error)     w_stat_run = StatAdr;
    else                       w_stat_run = StatAok;
  end

  assign w_halted = (r_state == StStopped);

  // Index only meaningful when legal; forced to 0 otherwise to keep reads in bounds.
  assign w_rd_idx = w_addr_ok ? w_addr[AW-1:0] : '0;
  assign w_st_idx = w_addr[AW-1:0];
  assign w_ld_idx = bus.load_addr[AW-1:0];

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      w_rdata[8*i +: 8] = r_mem[w_rd_idx + AW'(i)];
    end
  end

  // A stage write commits only for a fault-free instruction while running.
  assign w_stage_we = w_wr && w_addr_ok && !w_halted && !reset && (w_stat_run == StatAok);
  assign w_load_we  = bus.load_en && (bus.load_addr <= LastAddr) && !reset;

  // Preload loop comes second so it wins on overlapping bytes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (w_stage_we) r_mem[w_st_idx + AW'(i)] <= w_wdata[8*i +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      if (w_load_we) r_mem[w_ld_idx + AW'(i)] <= bus.load_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StRun;
      r_stat_q <= StatAok;
    end else begin
      case (r_state)
        StRun: begin
          if (w_stat_run != StatAok) begin
            r_state  <= StStopped;
            r_stat_q <= w_stat_run;
          end
        end
        StStopped: ;
        default: r_state <= StRun;
      endcase
    end
  end

  assign bus.stat       = reset ? StatAok : (w_halted ? r_stat_q : w_stat_run);
  assign bus.halted     = w_halted;
  assign bus.dmem_error = w_dmem_error;
  assign bus.valM       = (w_rd && w_addr_ok && !w_halted && !reset) ? w_rdata : '0;

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  logic clk;
  logic reset;
  memory_access_if bus ();

  memory_access #(.MEM_BYTES(1024)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int SelValM = 0;
  localparam int SelErr  = 1;
  localparam int SelStat = 2;
  localparam int SelHalt = 3;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [63:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SelValM: got = bus.valM;
        SelErr:  got = 64'(bus.dmem_error);
        SelStat: got = 64'(bus.stat);
        default: got = 64'(bus.halted);
      endcase
      check(e.tag, got, e.exp);
    end
  endtask

  // Compare pending expectations on the settled combinational outputs, then clock.
  task automatic step();
    #2;
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [3:0] ic, input logic [63:0] va, input logic [63:0] ve,
                       input logic [63:0] vp);
    bus.icode       = ic;
    bus.instr_valid = 1'b1;
    bus.imem_error  = 1'b0;
    bus.valA        = va;
    bus.valE        = ve;
    bus.valP        = vp;
    bus.load_en     = 1'b0;
    bus.load_addr   = '0;
    bus.load_data   = '0;
  endtask

  task automatic preload(input logic [63:0] a, input logic [63:0] d);
    instr(4'h1, '0, '0, '0);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    push("preload_stat", SelStat, 64'd1);
    step();
  endtask

  // One reset cycle; checks the forced outputs while reset is high.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    push({tag, "_rst_stat"}, SelStat, 64'd1);
    push({tag, "_rst_valm"}, SelValM, 64'd0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    instr(4'h1, '0, '0, '0);
    do_reset("por0");
    do_reset("por1");

    instr(4'h1, '0, '0, '0);
    push("run_halted", SelHalt, 64'd0);
    push("run_stat", SelStat, 64'd1);
    step();

    preload(64'h100, 64'h0);
    preload(64'h3F8, 64'h0123_4567_89AB_CDEF);

    // Write then read back
    instr(4'h4, 64'h1122_3344_5566_7788, 64'h100, 64'h0);
    push("rmmov_err", SelErr, 64'd0);
    push("rmmov_valm", SelValM, 64'd0);
    step();
    check("byte_0x100", 64'(dut.r_mem[256]), 64'h88);
    instr(4'h5, '0, 64'h100, '0);
    push("mrmov_valm", SelValM, 64'h1122_3344_5566_7788);
    push("mrmov_stat", SelStat, 64'd1);
    step();

    // Upper legal boundary
    instr(4'h5, '0, 64'h3F8, '0);
    push("edge_err", SelErr, 64'd0);
    push("edge_valm", SelValM, 64'h0123_4567_89AB_CDEF);
    step();

    // Stack ops
    instr(4'h8, '0, 64'h200, 64'h40);
    push("call_err", SelErr, 64'd0);
    step();
    instr(4'h9, 64'h200, 64'h208, '0);
    push("ret_valm", SelValM, 64'h40);
    step();
    instr(4'hA, 64'hDEAD_BEEF, 64'h1F8, '0);
    push("push_stat", SelStat, 64'd1);
    step();
    instr(4'hB, 64'h1F8, 64'h200, '0);
    push("pop_valm", SelValM, 64'hDEAD_BEEF);
    step();

    // Collision: preload wins; illegal preload dropped
    instr(4'h4, 64'h1, 64'h80, '0);
    bus.load_en   = 1'b1;
    bus.load_addr = 64'h80;
    bus.load_data = 64'h2;
    step();
    preload(64'h3F9, 64'hFFFF_FFFF_FFFF_FFFF);
    instr(4'h5, '0, 64'h80, '0);
    push("collide_valm", SelValM, 64'h2);
    step();
    instr(4'h5, '0, 64'h3F8, '0);
    push("drop_valm", SelValM, 64'h0123_4567_89AB_CDEF);
    step();

    // Out-of-range read faults and stops
    instr(4'h5, '0, 64'h3F9, '0);
    push("oob_err", SelErr, 64'd1);
    push("oob_stat", SelStat, 64'd3);
    push("oob_valm", SelValM, 64'd0);
    step();
    instr(4'h1, '0, '0, '0);
    push("oob_halted", SelHalt, 64'd1);
    push("oob_hold", SelStat, 64'd3);
    step();
    // Writes and reads suppressed while stopped
    instr(4'h4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h100, '0);
    push("stop_wr_stat", SelStat, 64'd3);
    step();
    instr(4'h5, '0, 64'h100, '0);
    push("stop_rd_valm", SelValM, 64'd0);
    step();
    do_reset("r1");
    instr(4'h5, '0, 64'h100, '0);
    push("kept_valm", SelValM, 64'h1122_3344_5566_7788);
    push("kept_halted", SelHalt, 64'd0);
    step();

    // No wrap-around
    instr(4'h5, '0, 64'hFFFF_FFFF_FFFF_FFFC, '0);
    push("wrap_err", SelErr, 64'd1);
    push("wrap_stat", SelStat, 64'd3);
    step();
    do_reset("r2");

    // Status priority; a faulting rmmovq must not write
    instr(4'h4, 64'h9, 64'h80, '0);
    bus.imem_error = 1'b1;
    push("imem_stat", SelStat, 64'd3);
    step();
    do_reset("r3");
    instr(4'h5, '0, 64'h80, '0);
    push("nowrite_valm", SelValM, 64'h2);
    step();
    instr(4'h0, '0, '0, '0);
    bus.imem_error = 1'b1;
    push("prio_adr", SelStat, 64'd3);
    step();
    do_reset("r4");
    instr(4'h0, '0, '0, '0);
    bus.instr_valid = 1'b0;
    push("prio_ins", SelStat, 64'd4);
    step();
    instr(4'h1, '0, '0, '0);
    push("ins_hold", SelStat, 64'd4);
    push("ins_halted", SelHalt, 64'd1);
    step();
    do_reset("r5");
    instr(4'h0, '0, '0, '0);
    push("prio_hlt", SelStat, 64'd2);
    step();
    instr(4'h1, '0, '0, '0);
    push("hlt_hold", SelStat, 64'd2);
    push("hlt_halted", SelHalt, 64'd1);
    step();

    // Reset from STOPPED with a pending rmmovq: write suppressed
    instr(4'h4, 64'h77, 64'h80, '0);
    do_reset("r6");
    instr(4'h5, '0, 64'h80, '0);
    push("rst_nowr_valm", SelValM, 64'h2);
    push("rst_stat", SelStat, 64'd1);
    push("rst_halted", SelHalt, 64'd0);
    step();
    instr(4'h1, '0, '0, '0);
    push("aok_halted", SelHalt, 64'd0);
    push("aok_stat", SelStat, 64'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
